regfile_multiport: RTL and testbench

REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

---
 rtl/regfile_multiport.sv | 141 ++++++++++++++
 tb/tb_regfile_multiport.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// Multi-port register file with a reset sweep that clears every entry
// and preloads the stack pointer before accepting writes.
//
// Ports:
//   Clk           rising-edge clock
//   Rst           synchronous active-high reset, restarts the sweep
//   RegWrite      write enable, honoured only once Ready is high
//   WriteRegister write address (register 0 is hard-wired to zero)
//   WriteData     write data
//   ReadRegister  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   ReadData      registered read data, port i at [i*DATA_W +: DATA_W]
//   Ready         high once the sweep has finished
module regfile_multiport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int SP_INDEX = 29,
    parameter int SP_INIT  = 252,
    parameter int BYPASS   = 1
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     RegWrite,
    input  logic [ADDR_W-1:0]        WriteRegister,
    input  logic [DATA_W-1:0]        WriteData,
    input  logic [NUM_RD*ADDR_W-1:0] ReadRegister,
    output logic [NUM_RD*DATA_W-1:0] ReadData,
    output logic                     Ready
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] SP_ADDR   = ADDR_W'(SP_INDEX);
    localparam logic [DATA_W-1:0] SP_VAL    = DATA_W'(SP_INIT);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic              ready_q, ready_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [DATA_W-1:0] rdata_q [NUM_RD];
    logic [DATA_W-1:0] rdata_d [NUM_RD];
    logic [ADDR_W-1:0] raddr   [NUM_RD];

    logic              we_d;
    logic [ADDR_W-1:0] waddr_d;
    logic [DATA_W-1:0] wdata_d;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_port
        assign raddr[g] = ReadRegister[g*ADDR_W +: ADDR_W];
        assign ReadData[g*DATA_W +: DATA_W] = rdata_q[g];
    end

    assign Ready = ready_q;

    // Controller and single write port.
    // The sweep owns the write port in INIT, so RegWrite is ignored there.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        ready_d = ready_q;
        we_d    = 1'b0;
        waddr_d = '0;
        wdata_d = '0;
        unique case (state_q)
            ST_INIT: begin
                we_d    = 1'b1;
                waddr_d = sweep_q;
                if (sweep_q == SP_ADDR) begin
                    wdata_d = SP_VAL;
                end
                if (sweep_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end else begin
                    sweep_d = sweep_q + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                we_d    = RegWrite && (WriteRegister != '0);
                waddr_d = WriteRegister;
                wdata_d = WriteData;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
        // Reset wins over any pending write on the same edge.
        if (Rst) begin
            we_d = 1'b0;
        end
    end

    // Read ports: next-cycle data is computed here and registered,
    // so ReadData itself never depends combinationally on inputs.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rdata_d[i] = '0;
            if (state_q == ST_RUN && raddr[i] != '0) begin
                if (BYPASS != 0 && we_d && WriteRegister == raddr[i]) begin
                    rdata_d[i] = WriteData;
                end else begin
                    rdata_d[i] = mem_q[raddr[i]];
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
            ready_q <= 1'b0;
            for (int i = 0; i < NUM_RD; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            ready_q <= ready_d;
            for (int i = 0; i < NUM_RD; i++) begin
                rdata_q[i] <= rdata_d[i];
            end
        end
    end

    // Storage has no reset of its own; the sweep provides it.
    always_ff @(posedge Clk) begin
        if (we_d) begin
            mem_q[waddr_d] <= wdata_d;
        end
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport: default, no-bypass and a
// small 16-bit/8-deep/3-port instance.
module tb_regfile_multiport;

    logic        Clk;
    logic        Rst;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [9:0]  ReadRegister;
    logic [63:0] m_rd;
    logic [63:0] nb_rd;
    logic        m_ready;
    logic        nb_ready;

    logic        s_rst;
    logic        s_we;
    logic [2:0]  s_wa;
    logic [15:0] s_wd;
    logic [8:0]  s_ra;
    logic [47:0] s_rd;
    logic        s_ready;

    regfile_multiport u_dut (
        .Clk(Clk), .Rst(Rst), .RegWrite(RegWrite),
        .WriteRegister(WriteRegister), .WriteData(WriteData),
        .ReadRegister(ReadRegister), .ReadData(m_rd), .Ready(m_ready)
    );

    regfile_multiport #(.BYPASS(0)) u_nb (
        .Clk(Clk), .Rst(Rst), .RegWrite(RegWrite),
        .WriteRegister(WriteRegister), .WriteData(WriteData),
        .ReadRegister(ReadRegister), .ReadData(nb_rd), .Ready(nb_ready)
    );

    regfile_multiport #(
        .DATA_W(16), .ADDR_W(3), .NUM_RD(3),
        .SP_INDEX(7), .SP_INIT(100), .BYPASS(1)
    ) u_sm (
        .Clk(Clk), .Rst(s_rst), .RegWrite(s_we),
        .WriteRegister(s_wa), .WriteData(s_wd),
        .ReadRegister(s_ra), .ReadData(s_rd), .Ready(s_ready)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int          sel;
        int          port;
        int          id;
        logic [31:0] exp;
    } ent_t;

    ent_t qa[$];
    ent_t qs[$];
    int   tests = 0;
    int   fails = 0;
    int   rid   = 0;
    logic issue_a = 1'b0;
    logic issue_s = 1'b0;
    logic rdv_a   = 1'b0;
    logic rdv_s   = 1'b0;

    always_ff @(posedge Clk) begin
        rdv_a <= issue_a;
        rdv_s <= issue_s;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] actual(input int sel, input int port);
        case (sel)
            0:       return m_rd[port*32 +: 32];
            1:       return nb_rd[port*32 +: 32];
            default: return {16'h0, s_rd[port*16 +: 16]};
        endcase
    endfunction

    task automatic pop_chk(inout ent_t q[$], input string tag);
        ent_t e;
        if (q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = q.pop_front();
            chk($sformatf("read%0d_dut%0d_port%0d", e.id, e.sel, e.port),
                actual(e.sel, e.port), e.exp);
        end
    endtask

    // Monitor: one registered read per issued request, checked the
    // negedge after the sampling edge.
    always @(negedge Clk) begin
        if (rdv_a) begin
            for (int k = 0; k < 4; k++) pop_chk(qa, "main");
        end
        if (rdv_s) begin
            for (int k = 0; k < 3; k++) pop_chk(qs, "small");
        end
    end

    task automatic tick;
        @(negedge Clk);
    endtask

    task automatic op(input logic we, input logic [4:0] wa,
                      input logic [31:0] wd,
                      input logic [4:0] a0, input logic [4:0] a1,
                      input logic rd,
                      input logic [31:0] e0, input logic [31:0] e1,
                      input logic [31:0] n0, input logic [31:0] n1);
        RegWrite      = we;
        WriteRegister = wa;
        WriteData     = wd;
        ReadRegister  = {a1, a0};
        if (rd) begin
            rid++;
            qa.push_back('{0, 0, rid, e0});
            qa.push_back('{0, 1, rid, e1});
            qa.push_back('{1, 0, rid, n0});
            qa.push_back('{1, 1, rid, n1});
            issue_a = 1'b1;
        end
        tick();
        issue_a  = 1'b0;
        RegWrite = 1'b0;
    endtask

    task automatic ops(input logic we, input logic [2:0] wa,
                       input logic [15:0] wd,
                       input logic [2:0] a0, input logic [2:0] a1,
                       input logic [2:0] a2, input logic rd,
                       input logic [31:0] e0, input logic [31:0] e1,
                       input logic [31:0] e2);
        s_we = we;
        s_wa = wa;
        s_wd = wd;
        s_ra = {a2, a1, a0};
        if (rd) begin
            rid++;
            qs.push_back('{2, 0, rid, e0});
            qs.push_back('{2, 1, rid, e1});
            qs.push_back('{2, 2, rid, e2});
            issue_s = 1'b1;
        end
        tick();
        issue_s = 1'b0;
        s_we    = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        Rst = 1'b1; RegWrite = 1'b0; WriteRegister = '0;
        WriteData = '0; ReadRegister = '0;
        s_rst = 1'b1; s_we = 1'b0; s_wa = '0; s_wd = '0; s_ra = '0;
        tick(); tick();
        chk("rst_ready", {31'd0, m_ready}, 32'd0);
        chk("rst_nb_ready", {31'd0, nb_ready}, 32'd0);
        chk("rst_rd0", m_rd[31:0], 32'd0);
        chk("rst_rd1", m_rd[63:32], 32'd0);

        // Sweep: Ready must rise on exactly the 32nd edge.
        Rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            if (k == 5) begin
                ReadRegister = {5'd5, 5'd29};
                rid++;
                qa.push_back('{0, 0, rid, 32'd0});
                qa.push_back('{0, 1, rid, 32'd0});
                qa.push_back('{1, 0, rid, 32'd0});
                qa.push_back('{1, 1, rid, 32'd0});
                issue_a = 1'b1;
            end
            tick();
            issue_a = 1'b0;
            chk($sformatf("sweep1_ready_e%0d", k), {31'd0, m_ready},
                {31'd0, k == 32});
            chk($sformatf("sweep1_nb_ready_e%0d", k), {31'd0, nb_ready},
                {31'd0, k == 32});
        end

        op(0, 0, 0, 29, 5, 1, 252, 0, 252, 0);
        op(1, 8, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
        op(0, 0, 0, 8, 8, 1, 32'hDEADBEEF, 32'hDEADBEEF,
           32'hDEADBEEF, 32'hDEADBEEF);
        op(1, 0, 32'h12345678, 0, 8, 1, 0, 32'hDEADBEEF,
           0, 32'hDEADBEEF);
        op(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        op(1, 9, 32'hA5A5A5A5, 9, 8, 1, 32'hA5A5A5A5, 32'hDEADBEEF,
           0, 32'hDEADBEEF);
        op(0, 0, 0, 9, 9, 1, 32'hA5A5A5A5, 32'hA5A5A5A5,
           32'hA5A5A5A5, 32'hA5A5A5A5);
        op(1, 31, 32'h0F0F0F0F, 0, 0, 0, 0, 0, 0, 0);
        op(1, 1, 32'h1, 31, 1, 1, 32'h0F0F0F0F, 32'h1,
           32'h0F0F0F0F, 32'h0);
        op(1, 29, 32'hCAFE, 29, 29, 1, 32'hCAFE, 32'hCAFE, 252, 252);
        op(0, 0, 0, 29, 31, 1, 32'hCAFE, 32'h0F0F0F0F,
           32'hCAFE, 32'h0F0F0F0F);

        // Reset in RUN with a simultaneous write, then reset mid-sweep.
        Rst = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd12;
        WriteData = 32'hFFFFFFFF;
        tick();
        chk("run_rst_ready", {31'd0, m_ready}, 32'd0);
        chk("run_rst_rd0", m_rd[31:0], 32'd0);
        Rst = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        chk("mid_ready", {31'd0, m_ready}, 32'd0);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            if (k == 32) RegWrite = 1'b1;
            tick();
            chk($sformatf("sweep2_ready_e%0d", k), {31'd0, m_ready},
                {31'd0, k == 32});
        end
        RegWrite = 1'b0;
        op(0, 0, 0, 12, 8, 1, 0, 0, 0, 0);
        op(0, 0, 0, 29, 9, 1, 252, 0, 252, 0);

        // Small configuration.
        tick();
        chk("s_rst_ready", {31'd0, s_ready}, 32'd0);
        s_rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("s_ready_e%0d", k), {31'd0, s_ready},
                {31'd0, k == 8});
        end
        ops(1, 3, 16'h1111, 0, 0, 0, 0, 0, 0, 0);
        ops(1, 5, 16'h2222, 0, 0, 0, 0, 0, 0, 0);
        ops(0, 0, 0, 7, 3, 5, 1, 100, 32'h1111, 32'h2222);
        ops(1, 6, 16'hBEEF, 6, 7, 0, 1, 32'hBEEF, 100, 0);
        ops(0, 0, 0, 6, 6, 3, 1, 32'hBEEF, 32'hBEEF, 32'h1111);

        tick(); tick();
        chk("main_queue_drained", qa.size(), 32'd0);
        chk("small_queue_drained", qs.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
